// File: rtl/prim_ram_cfg_mgr.sv
// prim_ram_cfg_mgr
// Applies runtime configuration to a group of prim_ram_* instances. Before a
// new setting is applied, new RAM requests are held off and any in-flight
// accesses are drained. After the apply, the hold stays up for a fixed settle
// interval. If the drain takes too long, the attempt is abandoned and the
// applied configuration is left untouched.
//
// Each RAM port owns two fields, fcfg (f=0) and lcfg (f=1). Each field is
// {cfg_en, cfg[CfgW-1:0]}. Field f of port p sits at [(2p+f)*FieldW +: FieldW].
//
// state    | meaning
// ---------+------------------------------------------------------------
// StIdle   | waiting for a commit; RAM free to run
// StDrain  | hold asserted; waiting for every port's busy to clear
// StApply  | enabled shadow fields copied into the applied config
// StSettle | hold kept asserted while the RAM settles on the new config
// StDone   | one-cycle completion pulse
// StAbort  | drain timed out; one-cycle timeout pulse, config untouched
module prim_ram_cfg_mgr #(
  parameter int NumPorts     = 2,
  parameter int CfgW         = 4,
  parameter int SettleCycles = 4,
  parameter int DrainTimeout = 16,
  localparam int FieldW      = CfgW + 1,
  localparam int TotW        = 2 * NumPorts * FieldW
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [TotW-1:0]     cfg_wdata_i,
  input  logic                cfg_commit_i,
  input  logic [NumPorts-1:0] ram_busy_i,
  output logic                ram_hold_o,
  output logic [TotW-1:0]     ram_cfg_o,
  output logic                cfg_busy_o,
  output logic                cfg_done_o,
  output logic                cfg_timeout_o,
  output logic                cfg_overrun_o
);

  localparam int NumFields = 2 * NumPorts;
  localparam int DrainW    = $clog2(DrainTimeout + 1);
  // A zero settle interval still needs a legal (1-bit) counter.
  localparam int SettleW   = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;

  localparam logic [DrainW-1:0]  DrainLimit = DrainW'(DrainTimeout);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SettleCycles);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDrain  = 3'd1,
    StApply  = 3'd2,
    StSettle = 3'd3,
    StDone   = 3'd4,
    StAbort  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [TotW-1:0]    shadow_q, shadow_d;
  logic [TotW-1:0]    ram_cfg_q, ram_cfg_d;
  logic [DrainW-1:0]  drain_cnt_q, drain_cnt_d;
  logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
  logic               overrun_q, overrun_d;

  // Register update for state, shadow, applied config, timers and overrun flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      shadow_q     <= '0;
      ram_cfg_q    <= '0;
      drain_cnt_q  <= '0;
      settle_cnt_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      ram_cfg_q    <= ram_cfg_d;
      drain_cnt_q  <= drain_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic: sequence a commit through drain, apply and settle.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    ram_cfg_d    = ram_cfg_q;
    drain_cnt_d  = drain_cnt_q;
    settle_cnt_d = settle_cnt_q;
    // A commit is only accepted in IDLE. A commit in any other state,
    // including the last cycle of DONE/ABORT, is flagged on the next cycle.
    overrun_d    = cfg_commit_i && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (cfg_commit_i) begin
          shadow_d    = cfg_wdata_i;
          drain_cnt_d = '0;
          state_d     = StDrain;
        end
      end

      StDrain: begin
        if (ram_busy_i == '0) begin
          state_d = StApply;
        end else begin
          // Count busy cycles, saturating. The attempt is abandoned once the
          // count reaches the limit.
          if (drain_cnt_q != DrainLimit) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
          if (drain_cnt_d == DrainLimit) begin
            state_d = StAbort;
          end
        end
      end

      StApply: begin
        // Only fields whose shadow enable bit is set are replaced. The whole
        // field is copied, including the enable bit.
        for (int k = 0; k < NumFields; k++) begin
          if (shadow_q[k*FieldW + CfgW]) begin
            ram_cfg_d[k*FieldW +: FieldW] = shadow_q[k*FieldW +: FieldW];
          end
        end
        settle_cnt_d = SettleLoad;
        state_d      = (SettleCycles == 0) ? StDone : StSettle;
      end

      StSettle: begin
        // Down-counter loaded with SettleCycles. A terminal count of 1 means
        // this is the last settle cycle.
        if (settle_cnt_q != '0) begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
        if (settle_cnt_q <= SettleW'(1)) begin
          state_d = StDone;
        end
      end

      StDone:  state_d = StIdle;
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // All outputs are decoded from registered state.
  assign ram_hold_o    = (state_q == StDrain) || (state_q == StApply) ||
                         (state_q == StSettle);
  assign cfg_busy_o    = (state_q != StIdle);
  assign cfg_done_o    = (state_q == StDone);
  assign cfg_timeout_o = (state_q == StAbort);
  assign cfg_overrun_o = overrun_q;
  assign ram_cfg_o     = ram_cfg_q;

endmodule

// File: tb/tb_prim_ram_cfg_mgr.sv
// Testbench for prim_ram_cfg_mgr with the default parameters.
// The reference model keeps track of when each update's events happen (drain
// start, apply, end), measured as cycle numbers. Every cycle, it derives the
// expected outputs from those cycle numbers.
module tb_prim_ram_cfg_mgr;

  localparam int S  = 4;
  localparam int DT = 16;
  localparam int FW = 5;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [TW-1:0] cfg_wdata = '0;
  logic          cfg_commit = 1'b0;
  logic [1:0]    ram_busy = 2'b00;
  logic          ram_hold, cfg_busy, cfg_done, cfg_timeout, cfg_overrun;
  logic [TW-1:0] ram_cfg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  prim_ram_cfg_mgr #(
    .NumPorts(2), .CfgW(4), .SettleCycles(S), .DrainTimeout(DT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_commit_i (cfg_commit),
    .ram_busy_i   (ram_busy),
    .ram_hold_o   (ram_hold),
    .ram_cfg_o    (ram_cfg),
    .cfg_busy_o   (cfg_busy),
    .cfg_done_o   (cfg_done),
    .cfg_timeout_o(cfg_timeout),
    .cfg_overrun_o(cfg_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic          m_active = 1'b0;
  logic          m_draining = 1'b0;
  logic          m_end_done = 1'b0;
  int            m_t_drain = 0;
  int            m_t_apply = -10;
  int            m_t_end = 0;
  int            m_ov_at = -10;
  logic [TW-1:0] m_shadow = '0;
  logic [TW-1:0] m_cfg = '0;

  always @(negedge clk) begin
    int n;
    logic e_busy, e_hold, e_done, e_to, e_ov;
    n = cyc;
    if (!rst_n) begin
      m_active = 1'b0; m_draining = 1'b0; m_cfg = '0; m_shadow = '0;
      m_ov_at = -10; m_t_apply = -10;
      chk("rst_hold", {31'd0, ram_hold}, 32'd0);
      chk("rst_busy", {31'd0, cfg_busy}, 32'd0);
      chk("rst_cfg", {12'd0, ram_cfg}, 32'd0);
    end else begin
      if (m_active && n == m_t_apply + 1) begin
        for (int k = 0; k < 4; k++)
          if (m_shadow[k*FW + 4]) m_cfg[k*FW +: FW] = m_shadow[k*FW +: FW];
      end
      if (m_active && n > m_t_end) m_active = 1'b0;
      e_busy = m_active && (n >= m_t_drain);
      e_hold = e_busy && (n < m_t_end);
      e_done = e_busy && (n == m_t_end) && m_end_done;
      e_to   = e_busy && (n == m_t_end) && !m_end_done;
      e_ov   = (n == m_ov_at);
      chk("hold", {31'd0, ram_hold}, {31'd0, e_hold});
      chk("busy", {31'd0, cfg_busy}, {31'd0, e_busy});
      chk("done", {31'd0, cfg_done}, {31'd0, e_done});
      chk("timeout", {31'd0, cfg_timeout}, {31'd0, e_to});
      chk("overrun", {31'd0, cfg_overrun}, {31'd0, e_ov});
      chk("ram_cfg", {12'd0, ram_cfg}, {12'd0, m_cfg});
      // fold in this cycle's inputs
      if (m_draining) begin
        if (ram_busy == 2'b00) begin
          m_t_apply = n + 1; m_t_end = n + 2 + S; m_end_done = 1'b1; m_draining = 1'b0;
        end else if (n - m_t_drain + 1 >= DT) begin
          m_t_end = n + 1; m_end_done = 1'b0; m_draining = 1'b0;
        end
      end
      if (cfg_commit) begin
        if (!m_active) begin
          m_active = 1'b1; m_draining = 1'b1; m_shadow = cfg_wdata;
          m_t_drain = n + 1; m_t_end = 32'h3FFF_FFFF; m_t_apply = -10;
        end else begin
          m_ov_at = n + 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic at(input int n);
    wait_until(n);
    @(negedge clk);
  endtask

  task automatic commit(input logic [TW-1:0] d);
    cfg_wdata = d; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  function automatic logic [TW-1:0] fld(input int k, input logic [4:0] v);
    logic [TW-1:0] r;
    r = '0;
    r[k*FW +: FW] = v;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("lit_reset_cfg", {12'd0, ram_cfg}, 32'd0);

    // all four fields enabled, values 3,5,7,9
    c0 = cyc;
    commit(20'hCDEB3);
    at(c0 + 1); chk("lit_t1_hold_c1", {31'd0, ram_hold}, 32'd1);
    at(c0 + 2); chk("lit_t1_cfg_c2", {12'd0, ram_cfg}, 32'd0);
    at(c0 + 3); chk("lit_t1_cfg_c3", {12'd0, ram_cfg}, 32'h000CDEB3);
    at(c0 + 6); chk("lit_t1_hold_c6", {31'd0, ram_hold}, 32'd1);
    at(c0 + 7); chk("lit_t1_done_c7", {31'd0, cfg_done}, 32'd1);
                chk("lit_t1_hold_c7", {31'd0, ram_hold}, 32'd0);
    at(c0 + 8); chk("lit_t1_idle_c8", {31'd0, cfg_busy}, 32'd0);
    tick();

    // port 0 fcfg to 0x12, then only port 1 lcfg enabled with 0xA
    c0 = cyc; commit(fld(0, 5'h12));
    at(c0 + 8); chk("lit_t2a_cfg", {12'd0, ram_cfg}, 32'h000CDEB2);
    tick();
    c0 = cyc; commit(fld(3, 5'h1A));
    at(c0 + 8); chk("lit_t2b_cfg", {12'd0, ram_cfg}, 32'h000D5EB2);
    tick();

    // no field enabled: full sequence, config unchanged
    c0 = cyc; commit({5'h07, 5'h0F, 5'h03, 5'h01});
    at(c0 + 7); chk("lit_t3_done", {31'd0, cfg_done}, 32'd1);
    at(c0 + 8); chk("lit_t3_cfg", {12'd0, ram_cfg}, 32'h000D5EB2);
    tick();

    // port 1 busy for 5 cycles after commit
    c0 = cyc; ram_busy = 2'b10;
    commit(fld(2, 5'h14));
    wait_until(c0 + 6); ram_busy = 2'b00;
    at(c0 + 7);  chk("lit_t4_cfg_c7", {12'd0, ram_cfg}, 32'h000D5EB2);
                 chk("lit_t4_hold_c7", {31'd0, ram_hold}, 32'd1);
    at(c0 + 8);  chk("lit_t4_cfg_c8", {12'd0, ram_cfg}, 32'h000D52B2);
    at(c0 + 11); chk("lit_t4_done_c11", {31'd0, cfg_done}, 32'd0);
    at(c0 + 12); chk("lit_t4_done_c12", {31'd0, cfg_done}, 32'd1);
    tick();

    // port 0 busy stuck: drain timeout
    c0 = cyc; ram_busy = 2'b01;
    commit(20'hFFFFF);
    at(c0 + 16); chk("lit_t5_to_c16", {31'd0, cfg_timeout}, 32'd0);
                 chk("lit_t5_hold_c16", {31'd0, ram_hold}, 32'd1);
    at(c0 + 17); chk("lit_t5_to_c17", {31'd0, cfg_timeout}, 32'd1);
                 chk("lit_t5_hold_c17", {31'd0, ram_hold}, 32'd0);
                 chk("lit_t5_cfg", {12'd0, ram_cfg}, 32'h000D52B2);
    at(c0 + 18); chk("lit_t5_idle", {31'd0, cfg_busy}, 32'd0);
    tick(); ram_busy = 2'b00;
    tick();

    // second commit during SETTLE is an overrun; first data applied
    c0 = cyc; commit(fld(0, 5'h11));
    wait_until(c0 + 4); commit(fld(0, 5'h1E));
    at(c0 + 5); chk("lit_t6_overrun", {31'd0, cfg_overrun}, 32'd1);
    at(c0 + 8); chk("lit_t6_cfg", {12'd0, ram_cfg}, 32'h000D52B1);
    tick();

    // commit in DONE cycle rejected, commit on the next cycle accepted
    c0 = cyc; commit(fld(1, 5'h16));
    wait_until(c0 + 7); commit(fld(1, 5'h18));
    commit(fld(1, 5'h19));
    at(c0 + 9);  chk("lit_t7_overrun", {31'd0, cfg_overrun}, 32'd0);
                 chk("lit_t7_busy", {31'd0, cfg_busy}, 32'd1);
    at(c0 + 16); chk("lit_t7_cfg", {12'd0, ram_cfg}, 32'h000D5331);
    tick();

    // async reset in SETTLE, then a normal update
    c0 = cyc; commit(fld(0, 5'h1C));
    wait_until(c0 + 4);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_t8_hold", {31'd0, ram_hold}, 32'd0);
    chk("lit_t8_busy", {31'd0, cfg_busy}, 32'd0);
    chk("lit_t8_done", {31'd0, cfg_done}, 32'd0);
    chk("lit_t8_to", {31'd0, cfg_timeout}, 32'd0);
    chk("lit_t8_ov", {31'd0, cfg_overrun}, 32'd0);
    chk("lit_t8_cfg", {12'd0, ram_cfg}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    c0 = cyc; commit(fld(3, 5'h1B));
    at(c0 + 7); chk("lit_t8_done_after", {31'd0, cfg_done}, 32'd1);
    at(c0 + 8); chk("lit_t8_cfg_after", {12'd0, ram_cfg}, 32'h000D8000);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
